nrisc_ula_mc: RTL and testbench
===============================

# nrisc_ula_mc

Multi-cycle, width-parametrised ALU for the NRISC datapath: the next-generation ULA. Keeps the 4-bit `ULA_ctrl` opcode and 3-bit flag model, adds a start/busy/done handshake, registered outputs, and iterative multiply/divide engines. The control unit issues one operation and stalls on `ULA_busy` until `ULA_done`.

## Interface

- `TAM`, 16, operand/result width; power of two, ≥ 4.
- `SHW`, `$clog2(TAM)`, shift-amount width (derived, not overridden).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ULA_A`  in  TAM  operand A.
- `ULA_B`  in  TAM  operand B.
- `ULA_ctrl`  in  4  opcode.
- `ULA_start`  in  1  issue request; sampled only while idle.
- `ULA_busy`  out  1  multi-cycle operation in progress.
- `ULA_done`  out  1  one-cycle pulse: `ULA_OUT`/`ULA_flags` updated.
- `ULA_OUT`  out  TAM  registered result; held until the next completion.
- `ULA_flags`  out  3  registered flags: [2] C, [1] N, [0] Z.

## Operation

- Opcodes:
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL
  - 7 SHR (logical)
  - 8 SAR
  - 9 ROL
  - A MUL (low TAM bits)
  - B MULH (high TAM bits, unsigned)
  - C DIVU (quotient)
  - D REMU (remainder)
  - E CMP
  - F PASS B
- Shift/rotate amount is `ULA_B[SHW-1:0]`; upper B bits are ignored.
- Flags:
  - Z = (result == 0); N = result[TAM-1].
  - C for ADD: carry out.
  - C for SUB/CMP: borrow (A < B unsigned).
  - C for SHL/SHR/SAR: last bit shifted out; C = 0 when the amount is 0.
  - C for ROL: result[0].
  - C for MUL: high half ≠ 0.
  - C for DIVU/REMU: B == 0.
  - C for all other ops: 0.
- CMP: `ULA_OUT` is not updated; flags are computed from A−B; `ULA_done` still pulses.
- Operands and opcode are latched at the accepting edge. Input changes after acceptance have no effect.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL: start with opcode A/B.
  - IDLE→DIV: start with opcode C/D.
  - All other opcodes complete in IDLE.
  - MUL and DIV each run exactly TAM iterations, then return to IDLE.
- MUL: shift-add over a 2·TAM-bit product register, one multiplier bit per cycle.
- DIV: restoring division, one quotient bit per cycle, with a TAM+1-bit partial remainder.
- Divide by zero is not special-cased. It runs the full TAM cycles and yields quotient all-ones and remainder = A, with C = 1.
- Iteration counter is `SHW+1` bits. It loads TAM on acceptance and decrements each cycle; completion occurs at count 1.

## Timing

- Reset (async assert, `rst` low): `ULA_OUT` = 0, `ULA_flags` = 3'b000, `ULA_done` = 0, `ULA_busy` = 0, FSM = IDLE, counter = 0.
- An asynchronous reset during MUL/DIV aborts the operation. No `ULA_done` is produced, and the previous result is not preserved.
- Single-cycle ops: `ULA_start` is sampled high at edge k. `ULA_OUT`, `ULA_flags` and `ULA_done` are updated at edge k. `ULA_done` deasserts at edge k+1 unless another op completes there. `ULA_busy` stays 0.
- Back-to-back single-cycle ops are accepted every cycle, so `ULA_done` can stay high continuously.
- MUL/DIV: accepted at edge k.
  - `ULA_busy` = 1 from edge k.
  - Result, flags and `ULA_done` = 1 at edge k+TAM.
  - `ULA_busy` = 0 at that same edge k+TAM.
- `ULA_start` while `ULA_busy` = 1 is ignored entirely; it is not queued.
- A new op can be accepted at edge k+TAM+1.
- `ULA_OUT`/`ULA_flags` never change except at a completion edge or on reset.

## Configuration

- Macro: `NRISC_ULA_MULDIV_EN`.
- Defined: MUL/DIV engines, the MUL and DIV states, and the counter are built; opcodes A–D behave as above.
- Undefined: the engines, MUL/DIV states and counter are omitted.
  - Opcodes A–D complete as single-cycle ops with `ULA_OUT` = 0 and flags = 3'b001 (Z only).
  - `ULA_busy` is tied to 0.

## Test plan

All scenarios use TAM = 16.

- ADD 0xFFFF + 0x0001 -> `ULA_OUT` = 0x0000 and flags = 3'b101, both at the start edge; `ULA_done` is a single pulse; `ULA_busy` never rises.
- MUL 0x0123 × 0x0100 -> `ULA_busy` is high for 16 cycles, then `ULA_OUT` = 0x2300 and C = 1. MULH with the same operands -> 0x0001. A `ULA_start` pulse at cycle 5 is ignored.
- DIVU 100/7 -> 0x000E after 16 cycles; REMU 100/7 -> 0x0002. DIVU 0x1234/0 -> 0xFFFF with flags = 3'b110.
- Drive `rst` low at cycle 5 of a DIVU -> `ULA_busy`, `ULA_done`, `ULA_OUT` and `ULA_flags` go to 0 immediately. After release, ADD 2+3 -> 0x0005.
- SAR 0x8000 by 3 -> 0xF000, flags = 3'b010. SHL 0x8001 by 1 -> 0x0002, C = 1. CMP 5,9 -> `ULA_OUT` unchanged, flags = 3'b110.
- Build without `NRISC_ULA_MULDIV_EN`: MUL 3×4 -> `ULA_OUT` = 0, flags = 3'b001, `ULA_done` at the start edge, `ULA_busy` stays 0.

Source files
------------

// File: rtl/nrisc_ula_mc.sv
// nrisc_ula_mc: multi-cycle NRISC ALU with start/busy/done handshake and registered result/flags.
// Iterative MUL/MULH/DIVU/REMU engines are built only when NRISC_ULA_MULDIV_EN is defined.
module nrisc_ula_mc #(
  parameter int TAM = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TAM-1:0] ULA_A,
  input  logic [TAM-1:0] ULA_B,
  input  logic [3:0]     ULA_ctrl,
  input  logic           ULA_start,
  output logic           ULA_busy,
  output logic           ULA_done,
  output logic [TAM-1:0] ULA_OUT,
  output logic [2:0]     ULA_flags
);
  localparam int SHW = $clog2(TAM);

  logic [SHW-1:0] sh;
  logic [TAM:0]   shl_t, shr_t, sar_t;
  logic [TAM-1:0] rol_res, sc_res;
  logic           sc_c;
  logic [2:0]     sc_flags;
  logic           accept, muldiv_issue;
  logic [TAM-1:0] out_q, out_d;
  logic [2:0]     flags_q, flags_d;
  logic           done_q, done_d;

  // Shifts run on a one-bit-wider word so the last bit shifted out lands in a fixed position.
  assign sh      = ULA_B[SHW-1:0];
  assign shl_t   = {1'b0, ULA_A} << sh;
  assign shr_t   = {ULA_A, 1'b0} >> sh;
  assign sar_t   = $unsigned($signed({ULA_A, 1'b0}) >>> sh);
  assign rol_res = (ULA_A << sh) | (ULA_A >> (TAM - int'(sh)));

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    case (ULA_ctrl)
      4'h0:       {sc_c, sc_res} = {1'b0, ULA_A} + {1'b0, ULA_B};
      4'h1, 4'hE: {sc_c, sc_res} = {1'b0, ULA_A} - {1'b0, ULA_B};
      4'h2:       sc_res = ULA_A & ULA_B;
      4'h3:       sc_res = ULA_A | ULA_B;
      4'h4:       sc_res = ULA_A ^ ULA_B;
      4'h5:       sc_res = ~ULA_A;
      4'h6:       {sc_c, sc_res} = shl_t;
      4'h7:       {sc_res, sc_c} = shr_t;
      4'h8:       {sc_res, sc_c} = sar_t;
      4'h9:       begin sc_res = rol_res; sc_c = rol_res[0]; end
      4'hF:       sc_res = ULA_B;
      default:    ;
    endcase
  end

  assign sc_flags = {sc_c, sc_res[TAM-1], sc_res == '0};

`ifdef NRISC_ULA_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
  state_e           state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [TAM-1:0]   opnd_q, opnd_d;
  logic             hi_q, hi_d;
  logic [2*TAM-1:0] prod_q, prod_d, prod_step;
  logic [TAM-1:0]   quo_q, quo_d, quo_step, rem_q, rem_d, rem_step;
  logic [TAM:0]     mul_sum, div_r, div_diff;
  logic             is_mul, is_div, fin, eng_c;
  logic [TAM-1:0]   eng_res;

  assign is_mul       = (ULA_ctrl[3:1] == 3'b101);
  assign is_div       = (ULA_ctrl[3:1] == 3'b110);
  assign accept       = ULA_start && (state_q == S_IDLE);
  assign muldiv_issue = is_mul || is_div;
  assign fin          = (state_q != S_IDLE) && (cnt_q == (SHW+1)'(1));

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum   = {1'b0, prod_q[2*TAM-1:TAM]} + {1'b0, opnd_q};
  assign prod_step = prod_q[0] ? {mul_sum, prod_q[TAM-1:1]} : {1'b0, prod_q[2*TAM-1:1]};

  // Restoring division; a divisor of zero always "fits", giving all-ones quotient and rem = A.
  assign div_r    = {rem_q, quo_q[TAM-1]};
  assign div_diff = div_r - {1'b0, opnd_q};
  assign quo_step = {quo_q[TAM-2:0], ~div_diff[TAM]};
  assign rem_step = div_diff[TAM] ? div_r[TAM-1:0] : div_diff[TAM-1:0];

  always_comb begin
    eng_res = '0;
    eng_c   = 1'b0;
    if (state_q == S_MUL) begin
      eng_res = hi_q ? prod_step[2*TAM-1:TAM] : prod_step[TAM-1:0];
      eng_c   = |prod_step[2*TAM-1:TAM];
    end else if (state_q == S_DIV) begin
      eng_res = hi_q ? rem_step : quo_step;
      eng_c   = (opnd_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
               else if (accept && is_div) state_d = S_DIV;
      default: if (fin) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ULA_busy = (state_q != S_IDLE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    opnd_d = opnd_q;
    hi_d   = hi_q;
    prod_d = prod_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    if (accept) begin
      cnt_d  = (SHW+1)'(TAM);
      opnd_d = is_div ? ULA_B : ULA_A;
      hi_d   = ULA_ctrl[0];
      prod_d = {{TAM{1'b0}}, ULA_B};
      quo_d  = ULA_A;
      rem_d  = '0;
    end else if (state_q != S_IDLE) begin
      cnt_d  = cnt_q - 1'b1;
      prod_d = prod_step;
      quo_d  = quo_step;
      rem_d  = rem_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      opnd_q <= '0;
      hi_q   <= 1'b0;
      prod_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      opnd_q <= opnd_d;
      hi_q   <= hi_d;
      prod_q <= prod_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
    end
  end
`else
  assign accept       = ULA_start;
  assign muldiv_issue = 1'b0;
  assign ULA_busy     = 1'b0;
`endif

  always_comb begin
    out_d   = out_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    if (accept && !muldiv_issue) begin
      if (ULA_ctrl != 4'hE) out_d = sc_res;
      flags_d = sc_flags;
      done_d  = 1'b1;
    end
`ifdef NRISC_ULA_MULDIV_EN
    if (fin) begin
      out_d   = eng_res;
      flags_d = {eng_c, eng_res[TAM-1], eng_res == '0};
      done_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q   <= '0;
      flags_q <= 3'b000;
      done_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign ULA_OUT   = out_q;
  assign ULA_flags = flags_q;
  assign ULA_done  = done_q;
endmodule

// File: tb/tb_nrisc_ula_mc.sv
// Self-checking bench for nrisc_ula_mc (TAM = 16): cycle model of the handshake plus literal vectors.
module tb_nrisc_ula_mc;
  localparam int TAM = 16;
`ifdef NRISC_ULA_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] ULA_A = '0, ULA_B = '0;
  logic [3:0]  ULA_ctrl = '0;
  logic        ULA_start = 1'b0;
  logic        ULA_busy, ULA_done;
  logic [15:0] ULA_OUT;
  logic [2:0]  ULA_flags;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  nrisc_ula_mc #(.TAM(TAM)) dut (
    .clk(clk), .rst(rst), .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_ctrl(ULA_ctrl),
    .ULA_start(ULA_start), .ULA_busy(ULA_busy), .ULA_done(ULA_done),
    .ULA_OUT(ULA_OUT), .ULA_flags(ULA_flags)
  );

  always #5 clk = ~clk;

  // Reference arithmetic for one operation, straight from the opcode table.
  function automatic void ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic [2:0] f);
    logic [31:0]        p;
    logic signed [31:0] sa;
    logic               c;
    int                 n;
    n  = int'(b[3:0]);
    sa = {{16{a[15]}}, a};
    p  = 32'(a) * 32'(b);
    r  = '0;
    c  = 1'b0;
    case (op)
      4'h0: begin p = 32'(a) + 32'(b); r = p[15:0]; c = p[16]; end
      4'h1, 4'hE: begin r = a - b; c = (a < b); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~a;
      4'h6: begin p = 32'(a) << n; r = p[15:0]; c = p[16]; end
      4'h7: begin r = a >> n; c = (n == 0) ? 1'b0 : a[n-1]; end
      4'h8: begin p = sa >>> n; r = p[15:0]; c = (n == 0) ? 1'b0 : a[n-1]; end
      4'h9: begin r = (a << n) | (a >> (16 - n)); c = r[0]; end
      4'hA: begin r = p[15:0];  c = (p[31:16] != 0); end
      4'hB: begin r = p[31:16]; c = (p[31:16] != 0); end
      4'hC: begin r = (b == 0) ? 16'hFFFF : a / b; c = (b == 0); end
      4'hD: begin r = (b == 0) ? a : a % b; c = (b == 0); end
      default: r = b;
    endcase
    if (!MD && op inside {[4'hA:4'hD]}) begin r = '0; c = 1'b0; end
    f = {c, r[15], r == 16'h0};
  endfunction

  logic [15:0] m_out = '0, pend_r = '0, mr;
  logic [2:0]  m_fl = '0, pend_f = '0, mf;
  logic        m_done = 1'b0, m_busy = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out = '0; m_fl = '0; m_done = 1'b0; m_busy = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_out = pend_r; m_fl = pend_f; m_done = 1'b1; m_busy = 1'b0; end
      end else if (ULA_start) begin
        ref_op(ULA_ctrl, ULA_A, ULA_B, mr, mf);
        if (MD && ULA_ctrl inside {[4'hA:4'hD]}) begin
          pend_r = mr; pend_f = mf; m_left = TAM; m_busy = 1'b1;
        end else begin
          if (ULA_ctrl != 4'hE) m_out = mr;
          m_fl = mf; m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({ULA_busy, ULA_done, ULA_OUT, ULA_flags} !== {m_busy, m_done, m_out, m_fl}) begin
        n_bad++;
        $display("FAIL model t=%0t got busy=%b done=%b out=%h fl=%b want busy=%b done=%b out=%h fl=%b",
                 $time, ULA_busy, ULA_done, ULA_OUT, ULA_flags, m_busy, m_done, m_out, m_fl);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    ULA_ctrl = op; ULA_A = a; ULA_B = b; ULA_start = 1'b1;
    @(negedge clk);
    ULA_start = 1'b0; ULA_A = 16'($urandom); ULA_B = 16'($urandom); ULA_ctrl = 4'($urandom);
  endtask

  task automatic run_multi(input bit poke, output int n);
    n = 0;
    while (ULA_busy && n < 40) begin
      n++;
      ULA_ctrl  = 4'h0;
      ULA_start = poke && (n == 5);
      @(negedge clk);
    end
    ULA_start = 1'b0;
    if (ULA_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_timeout got busy=%b want 0 within 40 cycles", ULA_busy);
    end
  endtask

  typedef struct { logic [3:0] op; logic [15:0] a, b, r; logic [2:0] f; } vec_t;
  vec_t vt[10] = '{
    '{4'h7, 16'h8001, 16'h0000, 16'h8001, 3'b010},
    '{4'h9, 16'h8001, 16'h0004, 16'h0018, 3'b000},
    '{4'h7, 16'h0003, 16'h0001, 16'h0001, 3'b100},
    '{4'h1, 16'h0003, 16'h0003, 16'h0000, 3'b001},
    '{4'h4, 16'hFFFF, 16'h0F0F, 16'hF0F0, 3'b010},
    '{4'h5, 16'h0000, 16'h1234, 16'hFFFF, 3'b010},
    '{4'hF, 16'h1234, 16'h0000, 16'h0000, 3'b001},
    '{4'h6, 16'h0001, 16'h0011, 16'h0002, 3'b000},
    '{4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 3'b000},
    '{4'h3, 16'h8000, 16'h0001, 16'h8001, 3'b010}
  };

  initial begin
    int n;
    logic [3:0] op;
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_out", ULA_OUT, 0);
    check("rst_flags", ULA_flags, 0);
    check("rst_done", ULA_done, 0);
    check("rst_busy", ULA_busy, 0);
    chk_en = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    issue(4'h0, 16'hFFFF, 16'h0001);
    check("add_out", ULA_OUT, 16'h0000);
    check("add_flags", ULA_flags, 3'b101);
    check("add_done", ULA_done, 1);
    check("add_busy", ULA_busy, 0);
    @(negedge clk);
    check("add_done_pulse", ULA_done, 0);

    issue(4'hA, 16'h0123, 16'h0100);
    run_multi(1'b1, n);
`ifdef NRISC_ULA_MULDIV_EN
    check("mul_busy_cycles", n, 16);
    check("mul_out", ULA_OUT, 16'h2300);
    check("mul_flags", ULA_flags, 3'b100);
`else
    check("mul_busy_cycles", n, 0);
    check("mul_out", ULA_OUT, 16'h0000);
    check("mul_flags", ULA_flags, 3'b001);
`endif
    check("mul_done", ULA_done, 1);
    @(negedge clk);
    check("mul_no_extra_done", ULA_done, 0);

    issue(4'hB, 16'h0123, 16'h0100);
    run_multi(1'b0, n);
    check("mulh_out", ULA_OUT, MD ? 16'h0001 : 16'h0000);
    issue(4'hC, 16'd100, 16'd7);
    run_multi(1'b0, n);
    check("divu_out", ULA_OUT, MD ? 16'h000E : 16'h0000);
    issue(4'hD, 16'd100, 16'd7);
    run_multi(1'b0, n);
    check("remu_out", ULA_OUT, MD ? 16'h0002 : 16'h0000);
    issue(4'hC, 16'h1234, 16'h0000);
    run_multi(1'b0, n);
    check("div0_out", ULA_OUT, MD ? 16'hFFFF : 16'h0000);
    check("div0_flags", ULA_flags, MD ? 3'b110 : 3'b001);

    issue(4'hC, 16'h1234, 16'h0005);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", ULA_busy, 0);
    check("abort_done", ULA_done, 0);
    check("abort_out", ULA_OUT, 0);
    check("abort_flags", ULA_flags, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    issue(4'h0, 16'd2, 16'd3);
    check("post_rst_add", ULA_OUT, 16'h0005);

    issue(4'h8, 16'h8000, 16'h0003);
    check("sar_out", ULA_OUT, 16'hF000);
    check("sar_flags", ULA_flags, 3'b010);
    issue(4'h6, 16'h8001, 16'h0001);
    check("shl_out", ULA_OUT, 16'h0002);
    check("shl_c", ULA_flags[2], 1);
    issue(4'hE, 16'd5, 16'd9);
    check("cmp_out_held", ULA_OUT, 16'h0002);
    check("cmp_flags", ULA_flags, 3'b110);
    check("cmp_done", ULA_done, 1);

    for (int i = 0; i < 10; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      check($sformatf("vec%0d_out", i), ULA_OUT, vt[i].r);
      check($sformatf("vec%0d_flags", i), ULA_flags, vt[i].f);
      check($sformatf("vec%0d_done", i), ULA_done, 1);
    end

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom);
      issue(op, 16'($urandom), (i % 7 == 0) ? 16'h0000 : 16'($urandom));
      if (ULA_busy) run_multi(i[0], n);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
